// File: rtl/instr_encode_loader_if.sv
// Descriptor handshake and instruction-memory write bus for instr_encode_loader.
// slave = encoder side, master = descriptor producer / memory observer.
interface instr_encode_loader_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic [2:0]        op_i;
   logic [4:0]        rd_i;
   logic [4:0]        rs1_i;
   logic [4:0]        rs2_i;
   logic [2:0]        funct3_i;
   logic              funct7b5_i;
   logic [31:0]       imm_i;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [31:0]       mem_data_o;

   modport slave (
      input  req_valid_i, op_i, rd_i, rs1_i, rs2_i,
      input  funct3_i, funct7b5_i, imm_i,
      output req_ready_o, mem_we_o, mem_addr_o, mem_data_o
   );

   modport master (
      output req_valid_i, op_i, rd_i, rs1_i, rs2_i,
      output funct3_i, funct7b5_i, imm_i,
      input  req_ready_o, mem_we_o, mem_addr_o, mem_data_o
   );
endinterface

// File: rtl/instr_encode_loader.sv
// RV32I descriptor encoder writing words to instruction memory at rising addresses.
// Define ENC_RANGE_CHECK_EN to flag out-of-range or misaligned immediates.
module instr_encode_loader #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   instr_encode_loader_if.slave bus,
   output logic [CNT_W-1:0]  count_o,
   output logic              active_o,
   output logic              err_o
);

   typedef enum logic [1:0] {
      S_IDLE, S_READY, S_ENC, S_WRITE
   } state_e;

   localparam logic [2:0] OP_R    = 3'd0;
   localparam logic [2:0] OP_I    = 3'd1;
   localparam logic [2:0] OP_LD   = 3'd2;
   localparam logic [2:0] OP_ST   = 3'd3;
   localparam logic [2:0] OP_BR   = 3'd4;
   localparam logic [2:0] OP_JAL  = 3'd5;
   localparam logic [2:0] OP_JALR = 3'd6;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [31:0]       data_q, data_d;
   logic [2:0]        op_q, op_d;
   logic [4:0]        rd_q, rd_d;
   logic [4:0]        rs1_q, rs1_d;
   logic [4:0]        rs2_q, rs2_d;
   logic [2:0]        f3_q, f3_d;
   logic              f7_q, f7_d;
   logic [31:0]       imm_q, imm_d;
   logic              pstart_q, pstart_d;
   logic              pstop_q, pstop_d;
   logic [ADDR_W-1:0] pbase_q, pbase_d;

   logic [31:0] word;
   logic        op_ok;
   logic        enc_ok;
   logic        go_stop;
   logic        go_start;
   logic        ready;
   logic        active;
   logic        we;

   always_comb begin
      word  = '0;
      op_ok = 1'b1;
      unique case (op_q)
         OP_R:    word = {1'b0, f7_q, 5'b0, rs2_q, rs1_q, f3_q,
                          rd_q, 7'b0110011};
         OP_I:    word = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0010011};
         OP_LD:   word = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0000011};
         OP_JALR: word = {imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b1100111};
         OP_ST:   word = {imm_q[11:5], rs2_q, rs1_q, f3_q,
                          imm_q[4:0], 7'b0100011};
         OP_BR:   word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                          imm_q[4:1], imm_q[11], 7'b1100011};
         OP_JAL:  word = {imm_q[20], imm_q[10:1], imm_q[11],
                          imm_q[19:12], rd_q, 7'b1101111};
         default: op_ok = 1'b0;
      endcase
   end

`ifdef ENC_RANGE_CHECK_EN
   logic fit12, fit13, fit21, rng_ok;
   // A value fits N signed bits when all bits from N-1 upward agree.
   assign fit12 = (&imm_q[31:11]) | ~(|imm_q[31:11]);
   assign fit13 = (&imm_q[31:12]) | ~(|imm_q[31:12]);
   assign fit21 = (&imm_q[31:20]) | ~(|imm_q[31:20]);

   always_comb begin
      rng_ok = 1'b1;
      unique case (op_q)
         OP_I, OP_LD, OP_JALR, OP_ST: rng_ok = fit12;
         OP_BR:   rng_ok = fit13 & ~imm_q[0];
         OP_JAL:  rng_ok = fit21 & ~imm_q[0];
         default: rng_ok = 1'b1;
      endcase
   end

   assign enc_ok = op_ok & rng_ok;
`else
   logic unused_imm;
   assign unused_imm = ^imm_q[31:21];
   assign enc_ok     = op_ok;
`endif

   assign go_stop  = stop_i | pstop_q;
   assign go_start = start_i | pstart_q;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      data_d   = data_q;
      op_d     = op_q;
      rd_d     = rd_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      f3_d     = f3_q;
      f7_d     = f7_q;
      imm_d    = imm_q;
      pstart_d = pstart_q;
      pstop_d  = pstop_q;
      pbase_d  = pbase_q;
      ready    = 1'b0;
      active   = 1'b0;
      we       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_READY;
               addr_d  = base_addr_i;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         S_READY: begin
            active   = 1'b1;
            ready    = ~go_stop;
            pstart_d = 1'b0;
            pstop_d  = 1'b0;
            if (go_stop) begin
               state_d = S_IDLE;
            end else begin
               if (go_start) begin
                  addr_d = start_i ? base_addr_i : pbase_q;
                  cnt_d  = '0;
                  err_d  = 1'b0;
               end
               if (bus.req_valid_i) begin
                  state_d = S_ENC;
                  op_d    = bus.op_i;
                  rd_d    = bus.rd_i;
                  rs1_d   = bus.rs1_i;
                  rs2_d   = bus.rs2_i;
                  f3_d    = bus.funct3_i;
                  f7_d    = bus.funct7b5_i;
                  imm_d   = bus.imm_i;
               end
            end
         end
         S_ENC: begin
            active = 1'b1;
            if (enc_ok) begin
               data_d  = word;
               state_d = S_WRITE;
            end else begin
               err_d   = 1'b1;
               state_d = S_READY;
            end
         end
         S_WRITE: begin
            active  = 1'b1;
            we      = 1'b1;
            addr_d  = addr_q + ADDR_W'(4);
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            state_d = S_READY;
         end
         default: state_d = S_IDLE;
      endcase
      // Session controls seen mid-encode are replayed on return to READY.
      if (state_q == S_ENC || state_q == S_WRITE) begin
         if (start_i) begin
            pstart_d = 1'b1;
            pbase_d  = base_addr_i;
         end
         if (stop_i) pstop_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         data_q   <= '0;
         op_q     <= '0;
         rd_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         f3_q     <= '0;
         f7_q     <= 1'b0;
         imm_q    <= '0;
         pstart_q <= 1'b0;
         pstop_q  <= 1'b0;
         pbase_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         data_q   <= data_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         f3_q     <= f3_d;
         f7_q     <= f7_d;
         imm_q    <= imm_d;
         pstart_q <= pstart_d;
         pstop_q  <= pstop_d;
         pbase_q  <= pbase_d;
      end
   end

   assign bus.req_ready_o = ready;
   assign bus.mem_we_o    = we;
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_data_o  = data_q;
   assign count_o         = cnt_q;
   assign active_o        = active;
   assign err_o           = err_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: directed descriptors with
// hand-encoded words; a negedge monitor checks every memory write.
module tb_instr_encode_loader;
   localparam int AW = 32;
   localparam int CW = 16;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          stop  = 1'b0;
   logic [AW-1:0] base  = '0;
   logic [CW-1:0] count;
   logic          active;
   logic          err;

   instr_encode_loader_if #(.ADDR_W(AW)) bus ();

   instr_encode_loader #(.ADDR_W(AW), .CNT_W(CW)) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .start_i     (start),
      .stop_i      (stop),
      .base_addr_i (base),
      .bus         (bus),
      .count_o     (count),
      .active_o    (active),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         sb[$];
   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_addr    = '0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (rst_n && bus.mem_we_o) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %h data %h want none",
                     bus.mem_addr_o, bus.mem_data_o);
         end else begin
            e = sb.pop_front();
            chk("wr_addr", bus.mem_addr_o, e.addr);
            chk("wr_data", bus.mem_data_o, e.data);
         end
      end
   end

   task automatic drive(input logic [2:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic f7,
                        input logic [31:0] imm);
      bus.op_i       = op;
      bus.rd_i       = rd;
      bus.rs1_i      = rs1;
      bus.rs2_i      = rs2;
      bus.funct3_i   = f3;
      bus.funct7b5_i = f7;
      bus.imm_i      = imm;
   endtask

   task automatic do_start(input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      base  = b;
      @(negedge clk);
      start    = 1'b0;
      exp_addr = b;
   endtask

   task automatic send(input logic [2:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [2:0] f3, input logic f7,
                       input logic [31:0] imm, input bit wr,
                       input logic [31:0] data);
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         if (bus.req_ready_o) break;
         @(negedge clk);
      end
      if (!bus.req_ready_o) begin
         chk("ready_timeout", 32'(bus.req_ready_o), 32'd1);
         return;
      end
      drive(op, rd, rs1, rs2, f3, f7, imm);
      bus.req_valid_i = 1'b1;
      if (wr) begin
         sb.push_back({exp_addr, data});
         exp_addr = exp_addr + 32'd4;
      end
      @(posedge clk);
      #1 bus.req_valid_i = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid_i = 1'b0;
      drive(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
      #22;
      chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
      chk("rst_active", 32'(active), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_we", 32'(bus.mem_we_o), 32'd0);
      chk("rst_addr", bus.mem_addr_o, 32'd0);
      chk("rst_data", bus.mem_data_o, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(bus.req_ready_o), 32'd0);

      do_start(32'h100);
      chk("start_active", 32'(active), 32'd1);
      chk("start_ready", 32'(bus.req_ready_o), 32'd1);

      send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1, 32'h0050_0093);
      chk("count_1", 32'(count), 32'd1);
      send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1, 32'h0020_81B3);
      send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8, 1, 32'h0020_A423);
      chk("count_3", 32'(count), 32'd3);
      chk("addr_10c", bus.mem_addr_o, 32'h10C);
      send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, -32'sd4, 1, 32'hFE00_0EE3);
      send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, 1, 32'h0080_00EF);
      send(3'd6, 5'd1, 5'd5, 5'd0, 3'd3, 1'b0, 32'd16, 1, 32'h0102_80E7);
      send(3'd2, 5'd2, 5'd1, 5'd0, 3'd2, 1'b0, -32'sd8, 1, 32'hFF80_A103);
      send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 1, 32'h4020_81B3);
      chk("count_8", 32'(count), 32'd8);

      send(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0, 0, 32'd0);
      chk("op7_err", 32'(err), 32'd1);
      chk("op7_addr", bus.mem_addr_o, 32'h120);
      chk("op7_count", 32'(count), 32'd8);

      do_start(32'h200);
      chk("restart_err", 32'(err), 32'd0);
      chk("restart_count", 32'(count), 32'd0);
`ifdef ENC_RANGE_CHECK_EN
      send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 0, 32'd0);
      chk("range_err", 32'(err), 32'd1);
      chk("range_addr", bus.mem_addr_o, 32'h200);
`else
      send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 1, 32'h8000_0093);
      chk("trunc_err", 32'(err), 32'd0);
      chk("trunc_addr", bus.mem_addr_o, 32'h204);
`endif

      do_start(32'hFFFF_FFFC);
      send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1, 32'h0050_0093);
      send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1, 32'h0050_0093);
      chk("wrap_count", 32'(count), 32'd2);
      chk("wrap_addr", bus.mem_addr_o, 32'h4);

      // stop while the word is in flight: write still lands, then IDLE
      @(negedge clk);
      drive(3'd1, 5'd4, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7);
      bus.req_valid_i = 1'b1;
      sb.push_back({exp_addr, 32'h0070_0213});
      exp_addr = exp_addr + 32'd4;
      @(posedge clk);
      #1 bus.req_valid_i = 1'b0;
      stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
      repeat (3) @(negedge clk);
      chk("lstop_active", 32'(active), 32'd0);
      chk("lstop_ready", 32'(bus.req_ready_o), 32'd0);
      chk("lstop_count", 32'(count), 32'd3);

      do_start(32'h300);
      @(negedge clk);
      stop = 1'b1;
      drive(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd9);
      bus.req_valid_i = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
      bus.req_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("stopv_active", 32'(active), 32'd0);
      chk("stopv_ready", 32'(bus.req_ready_o), 32'd0);
      chk("stopv_count", 32'(count), 32'd0);
      chk("stopv_addr", bus.mem_addr_o, 32'h300);

      do_start(32'h400);
      drive(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1);
      bus.req_valid_i = 1'b1;
      @(posedge clk);
      #1 bus.req_valid_i = 1'b0;
      @(posedge clk);
      #1 chk("wr_strobe", 32'(bus.mem_we_o), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_we", 32'(bus.mem_we_o), 32'd0);
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_active", 32'(active), 32'd0);
      chk("arst_ready", 32'(bus.req_ready_o), 32'd0);
      chk("arst_addr", bus.mem_addr_o, 32'd0);
      chk("arst_data", bus.mem_data_o, 32'd0);
      chk("arst_err", 32'(err), 32'd0);
      #10 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_ready", 32'(bus.req_ready_o), 32'd0);
      do_start(32'h500);
      chk("post_rst_start", 32'(bus.req_ready_o), 32'd1);

      repeat (2) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Sequential RV32I instruction encoder and instruction-memory writer: the producer side of the control decoder's opcode space.
- Accepts decoded instruction descriptors (class, registers, funct3, immediate) over a valid/ready handshake.
- Packs each descriptor into a 32-bit instruction word and writes it to instruction memory at an auto-incrementing word address.
- Used by testbenches and boot logic to load programs into the single-cycle CPU.

Parameters:
- ADDR_W, 32, width of mem_addr_o and base_addr_i.
- CNT_W, 16, width of count_o.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous reset, active-low.
- start_i  input  1  one-cycle pulse; opens a load session at base_addr_i.
- stop_i  input  1  one-cycle pulse; closes the session.
- base_addr_i  input  ADDR_W  first write address, captured on start_i.
- req_valid_i  input  1  descriptor valid.
- req_ready_o  output  1  encoder can accept a descriptor.
- op_i  input  3  class: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 reserved.
- rd_i  input  5  destination register.
- rs1_i  input  5  source register 1.
- rs2_i  input  5  source register 2.
- funct3_i  input  3  funct3 field.
- funct7b5_i  input  1  instruction bit 30 (R-type only).
- imm_i  input  32  signed immediate or byte offset.
- mem_we_o  output  1  instruction-memory write strobe.
- mem_addr_o  output  ADDR_W  write address.
- mem_data_o  output  32  encoded instruction.
- count_o  output  CNT_W  words written this session.
- active_o  output  1  session open.
- err_o  output  1  sticky encode error.

Behaviour:
- Reset (asynchronous, immediate, including mid-write): state IDLE; all outputs 0; address register 0.
- FSM states: IDLE, READY, ENC, WRITE.
- IDLE:
  - req_ready_o=0; requests are ignored.
  - start_i → READY; addr←base_addr_i; count_o←0; err_o←0.
- READY:
  - req_ready_o=1; active_o=1.
  - stop_i has priority over a same-cycle valid: go to IDLE, no descriptor accepted.
  - start_i in READY restarts the session: new base address, count_o and err_o cleared.
  - On req_valid_i & req_ready_o: register all descriptor fields → ENC.
- ENC (1 cycle, req_ready_o=0): compute the word from the registered fields.
  - R: {f7b5?0100000:0000000, rs2, rs1, funct3, rd, 0110011}.
  - I-ALU: {imm[11:0], rs1, funct3, rd, 0010011}.
  - LOAD: as I-ALU with opcode 0000011.
  - JALR: as I-ALU with opcode 1100111; funct3 forced to 000.
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
  - Valid encode → WRITE.
  - op_i=7 → err_o←1, no write, → READY.
- WRITE (1 cycle):
  - mem_we_o=1, with mem_addr_o and mem_data_o stable.
  - Next cycle: addr←addr+4 (wraps modulo 2^ADDR_W); count_o←count_o+1 (saturates at all-ones).
  - → READY.
- Timing:
  - Accept-to-strobe latency is 2 cycles.
  - Maximum throughput is 1 descriptor per 3 cycles.
  - mem_we_o is asserted in WRITE only.
- stop_i or start_i during ENC or WRITE is latched and acted on upon return to READY; the in-flight word is always written.
- err_o stays high until the next start_i or reset.

Optional Feature:
- Macro: ENC_RANGE_CHECK_EN.
- When defined, ENC raises err_o and suppresses the write if either condition holds:
  - imm_i does not fit its format's signed range (I/S: 12-bit; B: 13-bit; J: 21-bit).
  - B or J offset has imm_i[0]=1.
- When not defined, immediates are silently truncated to the format fields and err_o is driven only by op_i=7.

Test Plan:
- start_i with base 0x100, then I-ALU rd=1 rs1=0 f3=0 imm=5 → mem_we_o=1 two cycles after accept, addr 0x100, data 0x00500093, count_o=1.
- Then R rd=3 rs1=1 rs2=2 f3=0 f7b5=0 → addr 0x104, data 0x002081B3; then STORE rs1=1 rs2=2 f3=2 imm=8 → addr 0x108, data 0x0020A423, count_o=3.
- BRANCH rs1=rs2=0 f3=0 imm=-4 → 0xFE000EE3; JAL rd=1 imm=8 → 0x008000EF.
- op_i=7 → err_o=1, no mem_we_o, address unchanged; next start_i clears err_o. With ENC_RANGE_CHECK_EN: I-ALU imm=2048 → err_o=1, no write.
- Base 0xFFFFFFFC, two descriptors → writes at 0xFFFFFFFC then 0x00000000. stop_i asserted together with req_valid_i in READY → no accept, state IDLE.
- rst_i low during WRITE → mem_we_o drops immediately; all outputs 0; req_ready_o=0 until the next start_i.
